wave_gen: RTL and testbench
===========================

# wave_gen

Parametrised single-channel waveform generator for the LED/audio demo path. It combines a programmable prescaler with a wrapping phase accumulator. The phase is decoded into one of four waveform modes: saw up, saw down, triangle or square. Increment, mode and divider are loaded through a valid/ready configuration port. The registered output drives LEDs or a DAC directly.

## Interface
- ACC_W, 24, phase accumulator width; must be ≥ OUT_W+1
- OUT_W, 10, output sample width
- DIV_W, 25, prescaler divider width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- en  in  1  run enable; 0 freezes prescaler and phase
- cfg_valid  in  1  config request
- cfg_ready  out  1  config may be accepted
- cfg_inc  in  ACC_W  phase increment per tick
- cfg_mode  in  2  0 SAW_UP, 1 SAW_DOWN, 2 TRIANGLE, 3 SQUARE
- cfg_div  in  DIV_W  tick every cfg_div+1 enabled cycles
- out  out  OUT_W  registered sample
- wrap  out  1  one-cycle pulse, phase overflowed
- tick  out  1  one-cycle pulse, phase stepped

## Operation
- **Reset values:**
  - phase=0, count=0
  - active inc=0, mode=SAW_UP, div=0
  - no pending config
  - out=0, wrap=0, tick=0, cfg_ready=1
- **Prescaler:** when en=1:
  - if count==div_act: count←0 and a step occurs;
  - otherwise count←count+1.
  - en=0 holds count and phase.
- **Step:**
  - phase←(phase+inc_act) mod 2^ACC_W.
  - wrap=carry out of the add.
  - inc=0 gives no movement and no wrap.
- **Decode** f(p,m), with T = p[ACC_W-1 -: OUT_W]:
  - SAW_UP: T.
  - SAW_DOWN: ~T.
  - TRIANGLE: p[ACC_W-2 -: OUT_W] when p[ACC_W-1]=0, otherwise its bitwise inverse.
  - SQUARE: all ones when p[ACC_W-1]=0, otherwise 0.
- out is registered as f(phase_next, mode_next), so it always equals f(phase, mode_act) one edge later. A mode change is therefore visible immediately, even with no step.
- **Config handshake:**
  - Transfer occurs when cfg_valid & cfg_ready.
  - Fields are captured into a shadow register, pending is set and cfg_ready drops.
  - Applying the pending config loads inc/mode/div, sets count←0, clears pending and restores cfg_ready.
  - phase is never modified by config.
- Holding cfg_valid with cfg_ready=0 has no effect.
- Reset mid-operation discards any pending config.

## Timing
- A step is decided in cycle N, when en=1 and count==div_act. At the end of cycle N, phase, out, tick=1 and wrap are all written, so they are visible together in cycle N+1.
- tick and wrap are high for exactly one cycle per step. With div=0 and en=1 held, tick stays high continuously.
- Config accepted at edge E is applied at edge E+1 (default build). cfg_ready is low for one cycle, and the step decided in the cycle after E uses the old configuration.
- Step period = div_act+1 enabled cycles. Waveform period = 2^ACC_W/inc steps when inc divides evenly.

## Configuration
- WAVE_GEN_SYNC_UPDATE_EN defined:
  - Pending config is applied only at the edge where a wrapping step is written, or at the next edge if en=0.
  - The first step afterwards uses the new inc. count resets at that same edge.
  - cfg_ready stays low until the config is applied.
  - This gives glitch-free period boundaries.
- Undefined: config is applied one cycle after acceptance, as described in Timing.

## Structure
- Package wave_gen_pkg:
  - mode_t enum (SAW_UP, SAW_DOWN, TRIANGLE, SQUARE)
  - decode function f
  - default width localparams
- Sub-module wave_gen_prescaler: count/div_act, outputs step strobe, synchronous clear on config apply.
- The top level holds the phase accumulator, shadow config, handshake and output register.

## Test plan
All scenarios use ACC_W=8, OUT_W=4, DIV_W=4.
- **Reset:** reset during running output → next cycle out=0, wrap=0, tick=0, cfg_ready=1, and pending is dropped.
- **SAW_UP:** inc=16, div=0, en=1 → out steps 1,2,…,15,0. wrap pulses once every 16 cycles, in the cycle out returns to 0. SAW_DOWN produces the inverse sequence.
- **TRIANGLE:** inc=16 → out 2,4,…,14, then 15,13,…,1, then 0,2…. **SQUARE:** out=15 for phases 0–112 and 0 for phases 128–240.
- **Prescaler:** div=3 → tick every 4th cycle. Toggling en=0 for 5 cycles freezes phase, count and out.
- **inc=0:** no wrap ever, out constant. Switching mode with phase=144 → out recomputes the next cycle: SAW_UP 9, SAW_DOWN 6, TRIANGLE 13, SQUARE 0.
- **Config timing:**
  - Default build: config inc=32 accepted mid-period → cfg_ready is low for one cycle and inc=32 takes effect from the second step.
  - With WAVE_GEN_SYNC_UPDATE_EN: cfg_ready stays low until the next wrap, and the first post-wrap step adds 32.
  - Back-to-back cfg_valid is honoured only when cfg_ready=1.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared types, default widths and the waveform decode
// function for the wave_gen waveform generator.
package wave_gen_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int OUT_W_DEF = 10;
  localparam int DIV_W_DEF = 25;

  typedef enum logic [1:0] {
    SAW_UP   = 2'd0,
    SAW_DOWN = 2'd1,
    TRIANGLE = 2'd2,
    SQUARE   = 2'd3
  } mode_t;

  // Decode is purely bitwise, so it is expressed per output bit and stays
  // independent of the output width. t_hi is a bit of the top OUT_W phase
  // bits, t_lo the same bit position one phase bit lower (triangle slope),
  // msb is the phase MSB (half-period flag).
  function automatic logic wave_bit(input logic t_hi, input logic t_lo,
                                    input logic msb, input mode_t mode);
    logic b;
    case (mode)
      SAW_UP:   b = t_hi;
      SAW_DOWN: b = ~t_hi;
      TRIANGLE: b = msb ? ~t_lo : t_lo;
      default:  b = ~msb;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wave_gen_prescaler.sv
// wave_gen_prescaler: counts enabled cycles and raises a step strobe every
// div_act+1 of them. Loading a new divider also restarts the count.
module wave_gen_prescaler #(
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  output logic             step
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] div_act;

  assign step = en & (count == div_act);

  // Divider register and enabled-cycle counter; a load wins over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      div_act <= '0;
    end else if (load) begin
      count   <= '0;
      div_act <= div_in;
    end else if (en) begin
      count   <= step ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/wave_gen.sv
// wave_gen: prescaled phase accumulator with four decoded waveform modes and
// a valid/ready configuration port.
// Optional macro WAVE_GEN_SYNC_UPDATE_EN: hold a pending configuration until
// the edge that writes a wrapping step (or the next edge while en=0), so
// changes land on a period boundary. Without it, a configuration is applied
// one cycle after it is accepted.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [OUT_W-1:0] out,
  output logic             wrap,
  output logic             tick
);

  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] inc_act;
  mode_t            mode_act;
  logic             pending;
  logic [ACC_W-1:0] sh_inc;
  mode_t            sh_mode;
  logic [DIV_W-1:0] sh_div;

  logic             step_p0;
  logic             accept;
  logic             apply;
  logic [ACC_W:0]   sum_p0;
  logic [ACC_W-1:0] phase_next;
  mode_t            mode_next;
  logic [OUT_W-1:0] out_next;

  assign cfg_ready = ~pending;
  assign accept    = cfg_valid & ~pending;

  wave_gen_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .load   (apply),
    .div_in (sh_div),
    .step   (step_p0)
  );

  // Next phase, config-apply decision and decoded next sample.
  always_comb begin
    sum_p0     = {1'b0, phase} + {1'b0, inc_act};
`ifdef WAVE_GEN_SYNC_UPDATE_EN
    apply      = pending & ((step_p0 & sum_p0[ACC_W]) | ~en);
`else
    apply      = pending;
`endif
    phase_next = step_p0 ? sum_p0[ACC_W-1:0] : phase;
    mode_next  = apply ? sh_mode : mode_act;
    out_next   = '0;
    for (int i = 0; i < OUT_W; i++) begin
      out_next[i] = wave_bit(phase_next[ACC_W-OUT_W+i], phase_next[ACC_W-OUT_W-1+i],
                             phase_next[ACC_W-1], mode_next);
    end
  end

  // Stage p0 -> registered outputs: phase, active config, handshake, sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      inc_act  <= '0;
      mode_act <= SAW_UP;
      pending  <= 1'b0;
      out      <= '0;
      wrap     <= 1'b0;
      tick     <= 1'b0;
    end else begin
      phase <= phase_next;
      out   <= out_next;
      tick  <= step_p0;
      wrap  <= step_p0 & sum_p0[ACC_W];
      if (apply) begin
        inc_act  <= sh_inc;
        mode_act <= sh_mode;
        pending  <= 1'b0;
      end else if (accept) begin
        pending  <= 1'b1;
      end
    end
  end

  // Shadow configuration captured on a handshake; qualified by pending.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_inc  <= cfg_inc;
      sh_mode <= mode_t'(cfg_mode);
      sh_div  <= cfg_div;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed and randomized stimulus for wave_gen, checked every
// cycle against a behavioural model of the generator.
module tb_wave_gen;

  localparam int ACC_W = 8;
  localparam int OUT_W = 4;
  localparam int DIV_W = 4;
  localparam int PMOD  = 1 << ACC_W;
  localparam int HALF  = PMOD / 2;
  localparam int OMAX  = (1 << OUT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_inc;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_div;
  logic [OUT_W-1:0] out;
  logic             wrap;
  logic             tick;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int m_phase, m_count, m_inc, m_mode, m_div, m_pend;
  int s_inc, s_mode, s_div;
  int m_out, m_wrap, m_tick;
  int exp_tab[16];

  always #5 clk = ~clk;

  wave_gen #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .DIV_W (DIV_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_inc   (cfg_inc),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .out       (out),
    .wrap      (wrap),
    .tick      (tick)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_wave(input int p, input int m);
    int lvl;
    case (m)
      0: lvl = p / (PMOD >> OUT_W);
      1: lvl = OMAX - p / (PMOD >> OUT_W);
      2: lvl = (p < HALF) ? (p % HALF) / (HALF >> OUT_W)
                          : OMAX - (p % HALF) / (HALF >> OUT_W);
      default: lvl = (p < HALF) ? OMAX : 0;
    endcase
    return lvl;
  endfunction

  task automatic model_update();
    int sum;
    bit stp, cry, acc, apl;
    if (reset) begin
      m_phase = 0; m_count = 0; m_inc = 0; m_mode = 0; m_div = 0; m_pend = 0;
      m_out = 0; m_wrap = 0; m_tick = 0;
    end else begin
      acc = cfg_valid && (m_pend == 0);
      stp = en && (m_count == m_div);
      sum = m_phase + m_inc;
      cry = sum >= PMOD;
`ifdef WAVE_GEN_SYNC_UPDATE_EN
      apl = (m_pend != 0) && ((stp && cry) || !en);
`else
      apl = (m_pend != 0);
`endif
      if (stp) m_phase = sum % PMOD;
      if (apl) m_count = 0;
      else if (en) m_count = stp ? 0 : m_count + 1;
      if (apl) begin
        m_inc = s_inc; m_mode = s_mode; m_div = s_div; m_pend = 0;
      end
      m_out  = ref_wave(m_phase, m_mode);
      m_tick = stp;
      m_wrap = stp && cry;
      if (acc) begin
        s_inc = cfg_inc; s_mode = cfg_mode; s_div = cfg_div; m_pend = 1;
      end
    end
  endtask

  // one clock: model advances on the edge, DUT sampled 1 time unit later
  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check_val("out", out, m_out);
    check_val("wrap", wrap, m_wrap);
    check_val("tick", tick, m_tick);
    check_val("cfg_ready", cfg_ready, (m_pend == 0) ? 1 : 0);
  endtask

  task automatic send_cfg(input int inc, input int mode, input int div);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_inc   = inc[ACC_W-1:0];
    cfg_mode  = mode[1:0];
    cfg_div   = div[DIV_W-1:0];
    while (m_pend != 0 && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) check_val("cfg_timeout", n, 0);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic run16(input string tag, input int mode);
    en = 1'b0;
    send_cfg(16, mode, 0);
    cyc();
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      check_val(tag, out, exp_tab[k]);
      check_val({tag, "_wrap"}, wrap, (k == 15) ? 1 : 0);
    end
    en = 1'b0;
  endtask

  initial begin
    int nt, nw, saved;
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_inc = '0; cfg_mode = '0; cfg_div = '0;
    cyc();
    cyc();
    reset = 1'b0;
    check_val("rst_out", out, 0);
    check_val("rst_ready", cfg_ready, 1);
    check_val("rst_tick", tick, 0);

    // waveform sequences, each starting and ending at phase 0
    exp_tab = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0};
    run16("saw_up", 0);
    exp_tab = '{14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15};
    run16("saw_down", 1);
    exp_tab = '{2, 4, 6, 8, 10, 12, 14, 15, 13, 11, 9, 7, 5, 3, 1, 0};
    run16("triangle", 2);
    exp_tab = '{15, 15, 15, 15, 15, 15, 15, 0, 0, 0, 0, 0, 0, 0, 0, 15};
    run16("square", 3);

    // prescaler div=3 and freeze with en=0
    send_cfg(16, 0, 3);
    cyc();
    en = 1'b1;
    nt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      nt += int'(tick);
    end
    check_val("presc_ticks", nt, 3);
    for (int k = 0; k < 2; k++) cyc();
    en = 1'b0;
    cyc();
    saved = m_out;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check_val("freeze_out", out, saved);
      check_val("freeze_tick", tick, 0);
    end
    en = 1'b1;
    for (int k = 0; k < 8; k++) cyc();

    // inc=0, phase parked at 144, mode switches
    reset = 1'b1; en = 1'b0;
    cyc();
    reset = 1'b0;
    send_cfg(144, 0, 0);
    cyc();
    en = 1'b1;
    cyc();
    en = 1'b0;
    send_cfg(0, 0, 0);
    cyc();
    check_val("p144_saw_up", out, 9);
    send_cfg(0, 1, 0);
    cyc();
    check_val("p144_saw_down", out, 6);
    send_cfg(0, 2, 0);
    cyc();
    check_val("p144_triangle", out, 13);
    send_cfg(0, 3, 0);
    cyc();
    check_val("p144_square", out, 0);
    en = 1'b1;
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      nw += int'(wrap);
      check_val("inc0_out", out, 0);
    end
    check_val("inc0_wraps", nw, 0);

    // reset with a pending config drops it
    en = 1'b0;
    send_cfg(16, 0, 0);
    cyc();
    en = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    en = 1'b0;
    cfg_valid = 1'b1; cfg_inc = 8'd32;
    cyc();
    check_val("pend_ready", cfg_ready, 0);
    cfg_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_val("rst2_out", out, 0);
    check_val("rst2_wrap", wrap, 0);
    check_val("rst2_tick", tick, 0);
    check_val("rst2_ready", cfg_ready, 1);
    en = 1'b1;
    cyc();
    cyc();
    check_val("rst2_dropped", out, 0);

    // config timing mid-period; held valid while not ready is ignored
    en = 1'b0;
    send_cfg(16, 0, 0);
    cyc();
    en = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    cfg_valid = 1'b1; cfg_inc = 8'd32;
    cyc();
    check_val("cfgt_ready_e", cfg_ready, 0);
    cfg_inc = 8'd64;
    cyc();
`ifndef WAVE_GEN_SYNC_UPDATE_EN
    check_val("cfgt_old_step", out, 5);
    check_val("cfgt_ready_e1", cfg_ready, 1);
`endif
    cfg_valid = 1'b0;
    cyc();
`ifndef WAVE_GEN_SYNC_UPDATE_EN
    check_val("cfgt_new_step", out, 7);
`endif
    cyc();
`ifndef WAVE_GEN_SYNC_UPDATE_EN
    check_val("cfgt_new_step2", out, 9);
`endif
    for (int k = 0; k < 12; k++) cyc();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 99) < 2);
      en        = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 9) < 3);
      cfg_inc   = ACC_W'($urandom);
      cfg_mode  = 2'($urandom);
      cfg_div   = DIV_W'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
